// File: rtl/alu_seq_if.sv
// alu_seq_if: start/done handshake, operands and result/flag bundle of the sequential ALU.
// The master drives the request; the slave (alu_seq) returns the result and status.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       control;
    logic [WIDTH-1:0] out;
    logic             carryout;
    logic             overflow;
    logic             zero;
    logic             done;

    modport master (
        output start, A, B, control,
        input  ready, out, carryout, overflow, zero, done
    );

    modport slave (
        input  start, A, B, control,
        output ready, out, carryout, overflow, zero, done
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle WIDTH-bit ALU, SLICE bits per RUN cycle, LSB slice first, carry chained.
// Build macro ALU_SEQ_EARLY_DONE_EN: logic and illegal opcodes finish after a single RUN cycle.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic     clock,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam int NS   = WIDTH / SLICE;
    localparam int IDXW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NS - 1);

    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_NOR = 3'd6;
    localparam logic [2:0] OP_XOR = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One slice step: {carry_out, result}; logic ops report no carry, illegal ops yield zero.
    function automatic logic [SLICE:0] slice_op(input logic [2:0] op, input logic [SLICE-1:0] a,
                                                input logic [SLICE-1:0] b, input logic cin);
        logic [SLICE:0] r;
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b}  + {{SLICE{1'b0}}, cin};
            OP_SUB:  r = {1'b0, a} + {1'b0, ~b} + {{SLICE{1'b0}}, cin};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_NOR:  r = {1'b0, ~(a | b)};
            OP_XOR:  r = {1'b0, a ^ b};
            default: r = {(SLICE+1){1'b0}};
        endcase
        return r;
    endfunction

`ifdef ALU_SEQ_EARLY_DONE_EN
    function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction
`endif

    state_t           state_r, state_next_s;
    logic             ready_r;
    logic [WIDTH-1:0] a_r, b_r, acc_r, acc_next_s, out_r;
    logic [2:0]       ctrl_r;
    logic [IDXW-1:0]  idx_r;
    logic             carry_r;
    logic             carryout_r, overflow_r, zero_r, done_r;
    logic             accept_s, last_s, is_arith_s, bp_msb_s, ovf_s;
    logic [SLICE:0]   slice_s;

    // Next-state decode plus the current slice computation and completion flags.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        is_arith_s   = (ctrl_r == OP_ADD) || (ctrl_r == OP_SUB);
        slice_s      = slice_op(ctrl_r, a_r[idx_r*SLICE +: SLICE], b_r[idx_r*SLICE +: SLICE], carry_r);
        acc_next_s   = acc_r;
        acc_next_s[idx_r*SLICE +: SLICE] = slice_s[SLICE-1:0];
`ifdef ALU_SEQ_EARLY_DONE_EN
        if (is_arith_s) begin
            last_s = (idx_r == LAST_IDX);
        end else begin
            acc_next_s = logic_op(ctrl_r, a_r, b_r);
            last_s     = 1'b1;
        end
`else
        last_s = (idx_r == LAST_IDX);
`endif
        bp_msb_s = (ctrl_r == OP_SUB) ? ~b_r[WIDTH-1] : b_r[WIDTH-1];
        ovf_s    = is_arith_s && (a_r[WIDTH-1] == bp_msb_s) && (acc_next_s[WIDTH-1] != a_r[WIDTH-1]);
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next_s = ST_RUN;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    state_next_s = ST_RUN;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register; ready is registered from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s != ST_RUN);
        end
    end

    // Operand latch on acceptance, then slice-by-slice accumulation with the carry chain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            ctrl_r  <= 3'd0;
            idx_r   <= {IDXW{1'b0}};
            carry_r <= 1'b0;
            acc_r   <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            a_r     <= bus.A;
            b_r     <= bus.B;
            ctrl_r  <= bus.control;
            idx_r   <= {IDXW{1'b0}};
            carry_r <= (bus.control == OP_SUB);
        end else if (state_r == ST_RUN) begin
            idx_r   <= last_s ? {IDXW{1'b0}} : idx_r + IDXW'(1);
            carry_r <= slice_s[SLICE];
            acc_r   <= acc_next_s;
        end
    end

    // Result and flags change only on the completion edge; done pulses for that one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_r      <= {WIDTH{1'b0}};
            carryout_r <= 1'b0;
            overflow_r <= 1'b0;
            zero_r     <= 1'b1;
            done_r     <= 1'b0;
        end else begin
            done_r <= (state_r == ST_RUN) && last_s;
            if ((state_r == ST_RUN) && last_s) begin
                out_r      <= acc_next_s;
                carryout_r <= slice_s[SLICE];
                overflow_r <= ovf_s;
                zero_r     <= (acc_next_s == {WIDTH{1'b0}});
            end
        end
    end

    assign bus.ready    = ready_r;
    assign bus.out      = out_r;
    assign bus.carryout = carryout_r;
    assign bus.overflow = overflow_r;
    assign bus.zero     = zero_r;
    assign bus.done     = done_r;
endmodule
